lab9_soc_aes_in: RTL and testbench
==================================

# lab9_soc_aes_in

Avalon-MM slave input port for the Lab9 SoC, the read-side counterpart of the AES output port: it samples a WIDTH-bit fabric signal (AES core status/result word) into the clock domain, exposes it to the Nios II over a zero-wait-state register window, and latches per-bit edges into a sticky capture register that can raise a maskable interrupt. Sits on the system interconnect beside the output port; software polls or takes the IRQ to learn the AES core has finished.

## Interface
- WIDTH, 32, width of in_port and of every register (1..32)
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any
- SYNC_STAGES, 2, synchronizer depth on in_port (2..3)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  word address: 0 data, 1 reserved, 2 interrupt mask, 3 edge capture
- chipselect  in  1  slave selected
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, read latency 0
- in_port  in  WIDTH  asynchronous input from the AES core
- irq  out  1  level interrupt request

## Operation
- Reset: synchronizer stages, previous-sample register, mask and capture clear to 0; readdata 0 while address selects them; irq 0.
- Synchronizer: in_port passes through SYNC_STAGES flops; last stage is `sync`. `prev` registers `sync` each cycle.
- Edge detect (per bit): rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev.
- Capture update each cycle: cap <= edge | (cap & ~clr), clr = writedata[WIDTH-1:0] when chipselect & ~write_n & address==3, else 0. Write-one-to-clear; zero bits leave capture unchanged. Set wins over clear in the same cycle.
- Mask: written from writedata[WIDTH-1:0] on chipselect & ~write_n & address==2.
- Writes to address 0 or 1 are ignored.
- Read mux: addr 0 -> sync; 1 -> 0; 2 -> mask; 3 -> cap; zero-extended to 32 bits. readdata independent of chipselect/read strobe (no read side effects).
- irq = |(cap & mask), registered-free OR of registers.
- Upper writedata bits above WIDTH ignored.

## Timing
- in_port change before clock edge 1 -> visible in sync (address 0) after edge SYNC_STAGES.
- Capture bit set at edge SYNC_STAGES+1; irq high in the same cycle (combinational from cap).
- Clear write at edge N -> cap bit 0 and irq low after edge N, unless a new edge sets it at N.
- Mask write takes effect on irq the cycle after the write edge.
- Pulses shorter than one clock period may be lost; no guarantee below 2 clk periods.
- Reset asserted mid-operation clears all state immediately; first edge after reset release compares against prev=0, so a high input at release produces one rising capture.

## Configuration
- LAB9_SOC_AES_IN_IRQ_EN defined: mask register, irq logic present as above.
- Undefined: mask register absent, address 2 reads 0 and ignores writes, irq tied to 0; edge capture register and its clear still present.

## Structure
- Shared package lab9_soc_pkg: register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_CAP=3), EDGE_TYPE encoding constants.
- One sub-module: lab9_soc_sync_vec (WIDTH-bit, SYNC_STAGES-deep synchronizer, async active-high reset).

## Test plan
- Reset with in_port=32'hA5A5_0000 held -> all reads 0 during reset; after release, addr 0 reads 32'hA5A5_0000 after 2 edges; cap reads 32'hA5A5_0000 (rising from prev=0).
- EDGE_TYPE=0, mask=32'h1, in_port bit0 0->1 -> cap=32'h1 and irq=1 exactly 3 edges later; write 32'h1 to addr 3 -> cap=0, irq=0 next cycle.
- Clear write to addr 3 with 32'hFFFF_FFFF in the same cycle bit 4 rises -> cap bit 4 remains 1, others 0.
- mask=0, bit 7 rises -> cap=32'h80, irq=0; then write mask=32'h80 -> irq=1 next cycle.
- EDGE_TYPE=2, bit 3 toggles 1->0->1 at 4-cycle spacing, clear between -> each toggle sets cap bit 3.
- Macro undefined: write 32'hFFFF_FFFF to addr 2 -> read 0, irq stays 0 after any edge; write to addr 0 leaves reads tracking in_port.

Source files
------------

// File: rtl/lab9_soc_pkg.sv
// Shared definitions for the Lab9 SoC Avalon-MM input port.
//   Register word addresses on the slave window.
//   EDGE_TYPE encodings used by the capture logic.
package lab9_soc_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab9_soc_aes_in_if.sv
// Avalon-MM slave bus bundle for lab9_soc_aes_in.
//   address[1:0], chipselect, write_n, writedata[31:0] : master -> slave
//   readdata[31:0] (latency 0), irq (level)             : slave -> master
interface lab9_soc_aes_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/lab9_soc_sync_vec.sv
// Multi-flop synchronizer for a WIDTH-bit asynchronous vector.
//   clk, reset : clock, asynchronous active-high reset
//   i_d        : asynchronous input vector
//   o_q        : output of the last synchronizer stage
// Each bit is synchronized independently; no cross-bit coherence.
module lab9_soc_sync_vec #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stage <= '0;
    else       r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/lab9_soc_aes_in.sv
// Avalon-MM input port: samples the AES core status word, exposes it on a
// zero-wait-state register window, latches per-bit edges into a
// write-one-to-clear capture register and raises a maskable level IRQ.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata in,
//                readdata/irq out); 0 data, 1 reserved, 2 mask, 3 capture
//   in_port    : asynchronous WIDTH-bit input from the AES core
// Build option: define LAB9_SOC_AES_IN_IRQ_EN to include the interrupt mask
// register and irq logic; otherwise address 2 reads 0 and irq is tied low.
module lab9_soc_aes_in
  import lab9_soc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  lab9_soc_aes_in_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_mask;
  logic [31:0]      w_rdata;
  logic             w_wr;

  lab9_soc_sync_vec #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_port),
    .o_q   (w_sync)
  );

  assign w_wr = bus.chipselect & ~bus.write_n;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign w_edge = ~w_sync & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign w_edge = w_sync ^ r_prev;
    end else begin : g_rise
      assign w_edge = w_sync & ~r_prev;
    end
  endgenerate

  assign w_clr = (w_wr && bus.address == ADDR_CAP) ? bus.writedata[WIDTH-1:0] : '0;

  // prev resets to 0 so a high input at reset release yields one rising capture.
  // A new edge takes priority over a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
      r_cap  <= '0;
    end else begin
      r_prev <= w_sync;
      r_cap  <= w_edge | (r_cap & ~w_clr);
    end
  end

`ifdef LAB9_SOC_AES_IN_IRQ_EN
  logic [WIDTH-1:0] r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_mask <= '0;
    else if (w_wr && bus.address == ADDR_MASK) r_mask <= bus.writedata[WIDTH-1:0];
  end

  assign w_mask  = r_mask;
  assign bus.irq = |(r_cap & r_mask);
`else
  assign w_mask  = '0;
  assign bus.irq = 1'b0;
`endif

  // Read path ignores chipselect: reads have no side effects.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA: w_rdata[WIDTH-1:0] = w_sync;
      ADDR_MASK: w_rdata[WIDTH-1:0] = w_mask;
      ADDR_CAP:  w_rdata[WIDTH-1:0] = r_cap;
      default:   w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_lab9_soc_aes_in.sv
// Bench for lab9_soc_aes_in: three instances (rising, falling, any edge)
// share one stimulus stream and are compared every cycle with a reference
// model built on a queue of sampled inputs.
module tb_lab9_soc_aes_in;

  localparam int S = 2;
`ifdef LAB9_SOC_AES_IN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs, wn;
  logic [31:0] wdata, in_port;
  logic [31:0] rd [3];
  logic        irq_w [3];

  always #10 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      lab9_soc_aes_in_if bus_if ();
      assign bus_if.address    = address;
      assign bus_if.chipselect = cs;
      assign bus_if.write_n    = wn;
      assign bus_if.writedata  = wdata;
      assign rd[g]    = bus_if.readdata;
      assign irq_w[g] = bus_if.irq;
      lab9_soc_aes_in #(.WIDTH(32), .EDGE_TYPE(g), .SYNC_STAGES(S)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .in_port (in_port)
      );
    end
  endgenerate

  // Reference model: q_m holds the last S input samples, oldest first, so
  // q_m[0] is what software sees at address 0.
  logic [31:0] q_m [$];
  logic [31:0] prev_m, mask_m;
  logic [31:0] cap_m [3];
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    q_m.delete();
    for (int i = 0; i < S; i++) q_m.push_back(32'h0);
    prev_m = 0;
    mask_m = 0;
    for (int e = 0; e < 3; e++) cap_m[e] = 0;
  endtask

  task automatic model_edge();
    logic [31:0] s, clr, ev;
    if (reset) return;
    s   = q_m[0];
    clr = (cs && !wn && address == 2'd3) ? wdata : 32'h0;
    for (int e = 0; e < 3; e++) begin
      ev = (e == 0) ? (s & ~prev_m) : (e == 1) ? (~s & prev_m) : (s ^ prev_m);
      cap_m[e] = ev | (cap_m[e] & ~clr);
    end
    if (IRQ_ON && cs && !wn && address == 2'd2) mask_m = wdata;
    prev_m = s;
    q_m.push_back(in_port);
    void'(q_m.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sweep();
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      for (int e = 0; e < 3; e++) begin
        exp = (a == 0) ? q_m[0] : (a == 2) ? mask_m : (a == 3) ? cap_m[e] : 32'h0;
        check($sformatf("rd a%0d e%0d", a, e), rd[e], exp);
      end
    end
    for (int e = 0; e < 3; e++)
      check($sformatf("irq e%0d", e), {31'h0, irq_w[e]}, {31'h0, |(cap_m[e] & mask_m)});
  endtask

  task automatic tick(input logic [31:0] in, input logic wr, input logic [1:0] a,
                      input logic [31:0] d);
    in_port = in; cs = wr; wn = ~wr; address = a; wdata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cs = 1'b0; wn = 1'b1;
    sweep();
  endtask

  task automatic peek(input string tag, input int e, input logic [1:0] a,
                      input logic [31:0] exp);
    address = a;
    #1;
    check(tag, rd[e], exp);
  endtask

  logic [31:0] cur;

  initial begin
    reset = 1'b1; in_port = 32'hA5A5_0000; cs = 0; wn = 1; address = 0; wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    sweep();
    reset = 1'b0;

    // reset release: data after 2 edges, rising capture from prev=0
    cur = 32'hA5A5_0000;
    tick(cur, 0, 0, 0);
    tick(cur, 0, 0, 0);
    peek("post_rst_data", 0, 2'd0, 32'hA5A5_0000);
    tick(cur, 0, 0, 0);
    peek("post_rst_cap", 0, 2'd3, 32'hA5A5_0000);
    peek("post_rst_cap_fall", 1, 2'd3, 32'h0);
    tick(cur, 1, 2'd3, 32'hFFFF_FFFF);
    peek("clr_all", 0, 2'd3, 32'h0);

    // mask bit0, bit0 rises -> cap and irq three edges later, then clear
    tick(cur, 1, 2'd2, 32'h1);
    cur = 32'hA5A5_0001;
    tick(cur, 0, 0, 0);
    tick(cur, 0, 0, 0);
    peek("b0_not_yet", 0, 2'd3, 32'h0);
    tick(cur, 0, 0, 0);
    peek("b0_cap", 0, 2'd3, 32'h1);
    check("b0_irq", {31'h0, irq_w[0]}, {31'h0, IRQ_ON});
    tick(cur, 1, 2'd3, 32'h1);
    peek("b0_clr", 0, 2'd3, 32'h0);
    check("b0_irq_clr", {31'h0, irq_w[0]}, 32'h0);

    // clear-all in the same cycle bit4 rises: set wins
    cur = 32'hA5A5_0011;
    tick(cur, 0, 0, 0);
    tick(cur, 0, 0, 0);
    tick(cur, 1, 2'd3, 32'hFFFF_FFFF);
    peek("set_wins", 0, 2'd3, 32'h10);

    // mask=0, bit7 rises: cap only; unmask -> irq next cycle
    tick(cur, 1, 2'd2, 32'h0);
    tick(cur, 1, 2'd3, 32'hFFFF_FFFF);
    cur = 32'hA5A5_0091;
    repeat (3) tick(cur, 0, 0, 0);
    peek("b7_cap", 0, 2'd3, 32'h80);
    check("b7_irq_masked", {31'h0, irq_w[0]}, 32'h0);
    tick(cur, 1, 2'd2, 32'h80);
    check("b7_irq_unmask", {31'h0, irq_w[0]}, {31'h0, IRQ_ON});
    peek("mask_rd", 0, 2'd2, IRQ_ON ? 32'h80 : 32'h0);

    // any-edge: bit3 toggles at 4-cycle spacing, cleared between
    for (int k = 0; k < 3; k++) begin
      cur = cur ^ 32'h8;
      repeat (3) tick(cur, 0, 0, 0);
      peek($sformatf("any_b3_%0d", k), 2, 2'd3, rd[2] | 32'h8);
      check($sformatf("any_b3_set_%0d", k), rd[2] & 32'h8, 32'h8);
      tick(cur, 1, 2'd3, 32'hFFFF_FFFF);
    end

    // writes to data/reserved ignored, mask all-ones
    tick(cur, 1, 2'd0, 32'h1234_5678);
    tick(cur, 1, 2'd1, 32'hFFFF_FFFF);
    tick(cur, 1, 2'd2, 32'hFFFF_FFFF);
    peek("data_after_wr", 0, 2'd0, cur);

    // randomized traffic against the model, with one mid-run reset
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ $urandom;
      tick(cur, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      if (n == 150) begin
        reset = 1'b1;
        model_reset();
        #1;
        sweep();
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
